// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants, types and reorder table for the 8x8 DCT transpose buffer
package dct_pkg;

  localparam int W = 18;
  localparam int N = 8;

  typedef logic signed [W-1:0] coef_t;

  // Element k is the natural coefficient index of row-DCT output word k.
  localparam logic [7:0][2:0] DCT8_OUT_ORDER = {
    3'd7, 3'd5, 3'd3, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0
  };

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/dct_tbuf_bank.sv
// rtl/dct_tbuf_bank.sv - one 8x8 coefficient register bank: row write port, column read mux
module dct_tbuf_bank
  import dct_pkg::*;
(
  input  logic           clk,
  input  logic           wr_en,
  input  logic [2:0]     wr_row,
  input  logic [N*W-1:0] wr_data,
  input  logic [2:0]     rd_col,
  output logic [N*W-1:0] rd_data
);

  coef_t mem [N][N];

  // Contents are deliberately not reset; bank state in the top gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][c] <= wr_data[c*W +: W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++) begin
      rd_data[r*W +: W] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// rtl/dct_transpose_buf.sv - ping-pong 8x8 transpose buffer between row and column DCT passes
// Optional sticky dropped-row flag enabled by DCT_TBUF_DROP_DETECT_EN.
module dct_transpose_buf
  import dct_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row_flat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col_flat,
  output logic           out_last,
  output logic           err_drop
);

  bank_state_t    bank_state [2];
  logic           wr_bank;
  logic           rd_bank;
  logic [2:0]     wr_row;
  logic [2:0]     rd_col;
  logic [N*W-1:0] wr_row_nat;
  logic [N*W-1:0] rd_data [2];
  logic           wr_fire;
  logic           rd_fire;

  assign in_ready  = (bank_state[wr_bank] == BANK_EMPTY) || (bank_state[wr_bank] == BANK_FILLING);
  assign out_valid = (bank_state[rd_bank] == BANK_FULL) || (bank_state[rd_bank] == BANK_DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign out_col_flat = out_valid ? rd_data[rd_bank] : '0;
  assign out_last     = out_valid && (rd_col == 3'd7);

  // Undo the row-DCT output permutation so columns come out in natural order.
  always_comb begin
    wr_row_nat = '0;
    for (int k = 0; k < N; k++) begin
      wr_row_nat[DCT8_OUT_ORDER[k]*W +: W] = in_row_flat[k*W +: W];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tbuf_bank u_bank (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank == 1'(b))),
      .wr_row  (wr_row),
      .wr_data (wr_row_nat),
      .rd_col  (rd_col),
      .rd_data (rd_data[b])
    );
  end

  // A bank is only ever written or read in a given cycle, never both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_row        <= 3'd0;
      rd_col        <= 3'd0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_fire && (wr_bank == 1'(b))) begin
          bank_state[b] <= (wr_row == 3'd7) ? BANK_FULL : BANK_FILLING;
        end else if (rd_fire && (rd_bank == 1'(b))) begin
          bank_state[b] <= (rd_col == 3'd7) ? BANK_EMPTY : BANK_DRAINING;
        end
      end
      if (wr_fire) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) rd_bank <= ~rd_bank;
      end
    end
  end

`ifdef DCT_TBUF_DROP_DETECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_drop <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err_drop <= 1'b1;
    end
  end
`else
  assign err_drop = 1'b0;
`endif

endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb/tb_dct_transpose_buf.sv - self-checking bench for dct_transpose_buf
module tb_dct_transpose_buf;
  import dct_pkg::*;

  localparam int FW = N*W;

`ifdef DCT_TBUF_DROP_DETECT_EN
  localparam logic EXP_DROP = 1'b1;
`else
  localparam logic EXP_DROP = 1'b0;
`endif

  typedef struct packed {
    logic [FW-1:0] data;
    logic          last;
  } col_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [FW-1:0] in_row_flat = '0;
  logic          in_ready;
  logic          out_valid;
  logic [FW-1:0] out_col_flat;
  logic          out_last;
  logic          err_drop;

  int   tests = 0;
  int   fails = 0;
  col_t sb [$];
  logic [W-1:0] blk [8][8];
  int   order [8] = '{0, 4, 2, 6, 1, 3, 5, 7};
  int   stall_cnt = 0;
  int   gap_cnt = 0;
  logic track = 1'b0;
  logic seen = 1'b0;

  dct_transpose_buf dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row_flat  (in_row_flat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_col_flat (out_col_flat),
    .out_last     (out_last),
    .err_drop     (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_col", FW'(sb.size()), FW'(1));
      end else begin
        col_t e;
        e = sb.pop_front();
        check("col_data", out_col_flat, e.data);
        check("col_last", FW'(out_last), FW'(e.last));
        seen = 1'b1;
      end
    end
    if (track && seen && !out_valid && sb.size() > 0) gap_cnt++;
    if (track && !in_ready) stall_cnt++;
  end

  task automatic fill_pattern(input int b);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        blk[r][k] = W'(16*r + k + 256*b);
  endtask

  task automatic fill_neg();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        case ((r + k) % 3)
          0:       blk[r][k] = 18'h20000;
          1:       blk[r][k] = 18'h1FFFF;
          default: blk[r][k] = 18'h3FFFF - W'(r);
        endcase
  endtask

  task automatic push_expected();
    for (int c = 0; c < 8; c++) begin
      col_t e;
      e.data = '0;
      for (int r = 0; r < 8; r++)
        for (int k = 0; k < 8; k++)
          if (order[k] == c) e.data[r*W +: W] = blk[r][k];
      e.last = (c == 7);
      sb.push_back(e);
    end
  endtask

  task automatic wait_accept();
    int  n = 0;
    logic ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("accept_timeout", FW'(n), FW'(0));
  endtask

  task automatic send_block(input logic chk_lat);
    push_expected();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) in_row_flat[k*W +: W] = blk[r][k];
      in_valid = 1'b1;
      if (chk_lat && r == 7) check("lat_early", FW'(out_valid), FW'(0));
      wait_accept();
    end
    in_valid = 1'b0;
    if (chk_lat) check("lat_valid", FW'(out_valid), FW'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", FW'(sb.size()), FW'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", FW'(in_ready), FW'(1));
    check("rst_out_valid", FW'(out_valid), FW'(0));
    check("rst_out_last", FW'(out_last), FW'(0));
    check("rst_err_drop", FW'(err_drop), FW'(0));
    check("rst_out_col", out_col_flat, FW'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single block, out_ready high
    out_ready = 1'b1;
    fill_pattern(0);
    send_block(1'b1);
    drain();

    // Three blocks back-to-back
    gap_cnt = 0;
    stall_cnt = 0;
    seen = 1'b0;
    track = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      fill_pattern(b);
      send_block(1'b0);
    end
    drain();
    track = 1'b0;
    check("b2b_stalls", FW'(stall_cnt), FW'(0));
    check("b2b_gaps", FW'(gap_cnt), FW'(0));

    // Backpressure: both banks fill, output held
    out_ready = 1'b0;
    fill_pattern(4);
    send_block(1'b0);
    fill_pattern(5);
    send_block(1'b0);
    check("bp_in_ready", FW'(in_ready), FW'(0));
    check("bp_out_valid", FW'(out_valid), FW'(1));
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_data", out_col_flat, sb[0].data);
    check("bp_hold_last", FW'(out_last), FW'(0));
    in_row_flat = {FW{1'b1}};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("drop_flag", FW'(err_drop), FW'(EXP_DROP));
    check("bp_in_ready2", FW'(in_ready), FW'(0));
    check("bp_hold_data2", out_col_flat, sb[0].data);
    out_ready = 1'b1;
    drain();
    check("drop_sticky", FW'(err_drop), FW'(EXP_DROP));

    // Negative extremes pass unchanged
    fill_neg();
    send_block(1'b0);
    drain();

    // Reset asserted while column 3 is presented
    out_ready = 1'b0;
    fill_pattern(6);
    send_block(1'b0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("mid_col3", out_col_flat, sb[0].data);
    reset = 1'b0;
    #1;
    check("mr_in_ready", FW'(in_ready), FW'(1));
    check("mr_out_valid", FW'(out_valid), FW'(0));
    check("mr_out_last", FW'(out_last), FW'(0));
    check("mr_out_col", out_col_flat, FW'(0));
    check("mr_err_drop", FW'(err_drop), FW'(0));
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fill_pattern(7);
    send_block(1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
